eth_mii_tx: RTL and testbench

ETH_MII_TX -- requirements
Module: eth_mii_tx

---
 rtl/eth_mii_tx.sv | 258 +++++++++++++++++++++++++
 tb/tb_eth_mii_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mii_tx.sv
// eth_mii_tx -- byte-stream to MII (4-bit) Ethernet transmitter.
//
// Takes payload bytes over a valid/ready handshake into a one-byte buffer.
// Each frame goes out as a preamble of 15 x 0x5 and an SFD of 0xD, then the
// payload low nibble first. Optionally a CRC-32 FCS follows. The frame ends
// with an inter-frame gap of IFG_NIBBLES idle nibble slots. Nibble slots are
// CLK_DIV clk_in cycles long. The MII outputs change only on the clk_in edge
// where the internal tick is high.
//
// Optional feature: define ETH_TX_FCS_EN to append the 4-byte FCS.
// Without the macro there is no CRC logic and no FCS state.
//
// Parameters:
//   CLK_DIV      clk_in cycles per MII nibble slot
//   IFG_NIBBLES  idle nibble slots after each frame
// Ports:
//   clk_in     single clock, all logic in this domain
//   rst_n      asynchronous active-low reset
//   s_data     payload byte
//   s_valid    s_data/s_last valid
//   s_last     marks the final payload byte of a frame
//   s_ready    buffer empty, a byte is accepted this cycle if s_valid
//   mii_txd    MII transmit nibble
//   mii_tx_en  MII transmit enable
//   mii_tx_er  MII transmit error
//   busy       high whenever the transmitter is not IDLE

module eth_mii_tx #(
   parameter int CLK_DIV     = 4,
   parameter int IFG_NIBBLES = 24
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [3:0] mii_txd,
   output logic       mii_tx_en,
   output logic       mii_tx_er,
   output logic       busy
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SW = $clog2(IFG_NIBBLES + 16) + 1;

   typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, FCS, IFG} state_t;

   state_t          state, state_nxt;
   logic [SW-1:0]   slot_cnt, slot_nxt;
   logic            nib_hi, nib_hi_nxt;
   logic [3:0]      txd_nxt;
   logic            en_nxt, er_nxt;
   logic [DW-1:0]   div_cnt;
   logic            tick;
   logic [7:0]      buf_data;
   logic            buf_last, buf_full;
   logic            discard;
   logic            accept, drop, consume, underrun;
`ifdef ETH_TX_FCS_EN
   logic [31:0]     crc;
   logic [31:0]     fcs_word;
   logic            crc_clear;
`endif

   assign s_ready = !buf_full;
   assign busy    = (state != IDLE);
   assign tick    = (div_cnt == DW'(CLK_DIV - 1));
   assign accept  = s_valid && !buf_full;
   // Bytes arriving after an underrun belong to the aborted frame and are
   // swallowed until the one carrying s_last has gone by.
   assign drop    = accept && (discard || underrun);

   // Free-running slot divider; its wrap is the nibble tick.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   // One-byte input buffer and the post-underrun discard flag.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         buf_data <= '0;
         buf_last <= 1'b0;
         buf_full <= 1'b0;
         discard  <= 1'b0;
      end else begin
         if (accept && !drop) begin
            buf_data <= s_data;
            buf_last <= s_last;
            buf_full <= 1'b1;
         end else if (consume) begin
            buf_full <= 1'b0;
         end
         if (drop) begin
            discard <= !s_last;
         end else if (underrun) begin
            discard <= 1'b1;
         end
      end
   end

`ifdef ETH_TX_FCS_EN
   // Reflected CRC-32 advanced one byte at a time, LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                            input logic [7:0]  data);
      logic [31:0] c;
      c = crc_in ^ {24'd0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   assign fcs_word = ~crc;

   // Running CRC over payload bytes, restarted when the SFD goes out.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         crc <= 32'hFFFFFFFF;
      end else if (crc_clear) begin
         crc <= 32'hFFFFFFFF;
      end else if (consume) begin
         crc <= crc_byte(crc, buf_data);
      end
   end
`endif

   // FSM state and registered MII outputs.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         slot_cnt  <= '0;
         nib_hi    <= 1'b0;
         mii_txd   <= 4'h0;
         mii_tx_en <= 1'b0;
         mii_tx_er <= 1'b0;
      end else begin
         state     <= state_nxt;
         slot_cnt  <= slot_nxt;
         nib_hi    <= nib_hi_nxt;
         mii_txd   <= txd_nxt;
         mii_tx_en <= en_nxt;
         mii_tx_er <= er_nxt;
      end
   end

   // Next-state and next-nibble logic. Nothing moves except on a tick, so the
   // MII outputs hold for a whole slot.
   always_comb begin
      state_nxt  = state;
      slot_nxt   = slot_cnt;
      nib_hi_nxt = nib_hi;
      txd_nxt    = mii_txd;
      en_nxt     = mii_tx_en;
      er_nxt     = mii_tx_er;
      consume    = 1'b0;
      underrun   = 1'b0;
`ifdef ETH_TX_FCS_EN
      crc_clear  = 1'b0;
`endif
      if (tick) begin
         case (state)
            IDLE: begin
               txd_nxt = 4'h0;
               en_nxt  = 1'b0;
               er_nxt  = 1'b0;
               if (buf_full) begin
                  state_nxt = PREAMBLE;
                  slot_nxt  = SW'(1);
                  txd_nxt   = 4'h5;
                  en_nxt    = 1'b1;
               end
            end
            PREAMBLE: begin
               en_nxt = 1'b1;
               er_nxt = 1'b0;
               if (slot_cnt == SW'(15)) begin
                  txd_nxt    = 4'hD;
                  state_nxt  = DATA;
                  nib_hi_nxt = 1'b0;
`ifdef ETH_TX_FCS_EN
                  crc_clear  = 1'b1;
`endif
               end else begin
                  txd_nxt  = 4'h5;
                  slot_nxt = slot_cnt + SW'(1);
               end
            end
            DATA: begin
               en_nxt = 1'b1;
               er_nxt = 1'b0;
               if (!nib_hi) begin
                  if (buf_full) begin
                     txd_nxt    = buf_data[3:0];
                     nib_hi_nxt = 1'b1;
                  end else begin
                     underrun  = 1'b1;
                     txd_nxt   = 4'h0;
                     er_nxt    = 1'b1;
                     state_nxt = IFG;
                     slot_nxt  = '0;
                  end
               end else begin
                  txd_nxt    = buf_data[7:4];
                  nib_hi_nxt = 1'b0;
                  consume    = 1'b1;
                  if (buf_last) begin
`ifdef ETH_TX_FCS_EN
                     state_nxt = FCS;
`else
                     state_nxt = IFG;
`endif
                     slot_nxt  = '0;
                  end
               end
            end
`ifdef ETH_TX_FCS_EN
            FCS: begin
               en_nxt  = 1'b1;
               er_nxt  = 1'b0;
               txd_nxt = fcs_word[{slot_cnt[2:0], 2'b00} +: 4];
               if (slot_cnt == SW'(7)) begin
                  state_nxt = IFG;
                  slot_nxt  = '0;
               end else begin
                  slot_nxt = slot_cnt + SW'(1);
               end
            end
`endif
            IFG: begin
               txd_nxt = 4'h0;
               en_nxt  = 1'b0;
               er_nxt  = 1'b0;
               if (slot_cnt == SW'(IFG_NIBBLES - 1)) begin
                  state_nxt = IDLE;
                  slot_nxt  = '0;
               end else begin
                  slot_nxt = slot_cnt + SW'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               slot_nxt  = '0;
               txd_nxt   = 4'h0;
               en_nxt    = 1'b0;
               er_nxt    = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_mii_tx.sv
// tb_eth_mii_tx -- directed bench for eth_mii_tx (CLK_DIV=4, IFG_NIBBLES=24).
// A monitor records one {tx_er, tx_en, txd} entry per nibble slot. It also
// flags any output change inside a slot. Directed steps compare the recorded
// slots against hand-built expected sequences.

module tb_eth_mii_tx;

   localparam int CLK_DIV = 4;
   localparam int IFG     = 24;

   logic       clk_in = 1'b0;
   logic       rst_n  = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last  = 1'b0;
   logic       s_ready;
   logic [3:0] mii_txd;
   logic       mii_tx_en;
   logic       mii_tx_er;
   logic       busy;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         holdBad = 0;
   int         handshakes = 0;
   logic [5:0] slots[$];
   logic [5:0] expSlots[$];
   logic [7:0] payload[$];

   eth_mii_tx #(.CLK_DIV(CLK_DIV), .IFG_NIBBLES(IFG)) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .mii_txd   (mii_txd),
      .mii_tx_en (mii_tx_en),
      .mii_tx_er (mii_tx_er),
      .busy      (busy)
   );

   always #5 clk_in = ~clk_in;

   // Clock edges since reset release; slot boundaries fall on multiples of CLK_DIV.
   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Slot recorder, hold checker and handshake counter, all sampled mid-cycle.
   always @(negedge clk_in) begin
      if (rst_n) begin
         if (s_valid && s_ready) handshakes <= handshakes + 1;
         if (cyc != 0 && (cyc % CLK_DIV) == 0)
            slots.push_back({mii_tx_er, mii_tx_en, mii_txd});
         else if (slots.size() > 0 && {mii_tx_er, mii_tx_en, mii_txd} !== slots[$])
            holdBad <= holdBad + 1;
      end
   end

   task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present one byte, keep s_valid up until it is taken, end at posedge+1.
   task applyStimulus(input logic [7:0] data, input logic last);
      bit ok;
      ok      = 1'b0;
      s_data  = data;
      s_last  = last;
      s_valid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_in);
         if (s_ready) begin
            ok = 1'b1;
            @(posedge clk_in);
            #1;
            break;
         end
      end
      s_valid = 1'b0;
      checkOutput($sformatf("accept_%h", data), {31'd0, ok}, 32'd1);
   endtask

   function automatic int findStart();
      for (int i = 0; i < slots.size(); i++)
         if (slots[i][4]) return i;
      return -1;
   endfunction

   task waitFrame(input int need, input string tag);
      bit ok;
      int s;
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         s = findStart();
         if (s >= 0 && slots.size() >= s + need) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk_in);
         #1;
      end
      checkOutput({tag, "_wait"}, {31'd0, ok}, 32'd1);
   endtask

`ifdef ETH_TX_FCS_EN
   // Bit-serial reflected CRC-32 over the current payload queue.
   function automatic logic [31:0] crcModel();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (payload[i])
         for (int b = 0; b < 8; b++)
            c = (c[0] ^ payload[i][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction
`endif

   // Append preamble, SFD, payload nibbles, optional FCS and idle slots.
   task buildExpected(input int idleSlots, input bit withFcs);
      for (int i = 0; i < 15; i++) expSlots.push_back(6'h15);
      expSlots.push_back(6'h1D);
      foreach (payload[i]) begin
         expSlots.push_back({2'b01, payload[i][3:0]});
         expSlots.push_back({2'b01, payload[i][7:4]});
      end
      if (withFcs) begin
`ifdef ETH_TX_FCS_EN
         logic [31:0] fcs;
         fcs = ~crcModel();
         for (int i = 0; i < 8; i++) expSlots.push_back({2'b01, fcs[i*4 +: 4]});
`endif
      end
      for (int i = 0; i < idleSlots; i++) expSlots.push_back(6'h00);
   endtask

   task checkFrame(input string tag, input int start);
      logic [5:0] obs;
      for (int i = 0; i < expSlots.size(); i++) begin
         if (start >= 0 && start + i < slots.size()) obs = slots[start + i];
         else obs = 6'bx;
         checkOutput($sformatf("%s_slot%0d", tag, i), {26'd0, obs}, {26'd0, expSlots[i]});
      end
   endtask

   initial begin
      int s;
      int hs0;
      int enCount;

      // Reset state.
      repeat (3) @(posedge clk_in);
      #1;
      checkOutput("rst_txd",   {28'd0, mii_txd}, 32'd0);
      checkOutput("rst_en",    {31'd0, mii_tx_en}, 32'd0);
      checkOutput("rst_er",    {31'd0, mii_tx_er}, 32'd0);
      checkOutput("rst_busy",  {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      checkOutput("rst_ready", {31'd0, s_ready}, 32'd1);

      // Single byte 0xA7 right after reset: frame begins on the very first tick.
      $display("[TB] single byte frame");
      payload = '{8'hA7};
      expSlots.delete();
      buildExpected(IFG + 2, 1'b1);
      applyStimulus(8'hA7, 1'b1);
      waitFrame(5, "single_mid");
      checkOutput("single_busy_mid", {31'd0, busy}, 32'd1);
      waitFrame(expSlots.size(), "single");
      checkOutput("single_start", findStart(), 32'd0);
      checkFrame("single", findStart());
      checkOutput("single_busy_end", {31'd0, busy}, 32'd0);

      // Two 2-byte frames back to back: exactly IFG idle slots between them.
      $display("[TB] back-to-back frames");
      slots.delete();
      expSlots.delete();
      payload = '{8'h12, 8'h34};
      buildExpected(IFG, 1'b1);
      payload = '{8'h56, 8'h78};
      buildExpected(2, 1'b1);
      applyStimulus(8'h12, 1'b0);
      applyStimulus(8'h34, 1'b1);
      applyStimulus(8'h56, 1'b0);
      applyStimulus(8'h78, 1'b1);
      waitFrame(expSlots.size(), "b2b");
      checkFrame("b2b", findStart());

      // Underrun after the first of three bytes.
      $display("[TB] underrun");
      slots.delete();
      expSlots.delete();
      payload = '{8'h11};
      buildExpected(0, 1'b0);
      expSlots.push_back(6'h30);
      for (int i = 0; i < IFG + 6; i++) expSlots.push_back(6'h00);
      hs0 = handshakes;
      applyStimulus(8'h11, 1'b0);
      waitFrame(19, "under_err");
      applyStimulus(8'h22, 1'b0);
      applyStimulus(8'h33, 1'b1);
      waitFrame(expSlots.size(), "under");
      s = findStart();
      checkFrame("under", s);
      enCount = 0;
      for (int i = s + 19; i < slots.size(); i++) if (slots[i][4]) enCount++;
      checkOutput("under_no_tx", enCount, 32'd0);
      checkOutput("under_handshakes", handshakes - hs0, 32'd3);
      checkOutput("under_ready", {31'd0, s_ready}, 32'd1);
      checkOutput("under_busy", {31'd0, busy}, 32'd0);

      // Continuous s_valid: one handshake per byte, nothing lost or repeated.
      $display("[TB] streaming frame");
      slots.delete();
      expSlots.delete();
      payload = '{8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h96, 8'h69};
      buildExpected(2, 1'b1);
      hs0 = handshakes;
      foreach (payload[i]) applyStimulus(payload[i], (i == 5));
      waitFrame(expSlots.size(), "stream");
      checkFrame("stream", findStart());
      checkOutput("stream_handshakes", handshakes - hs0, 32'd6);

`ifdef ETH_TX_FCS_EN
      // Check value payload "123456789" -> FCS nibbles of 0xCBF43926.
      $display("[TB] fcs check value");
      slots.delete();
      expSlots.delete();
      payload = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      buildExpected(0, 1'b0);
      expSlots.push_back(6'h16); expSlots.push_back(6'h12);
      expSlots.push_back(6'h19); expSlots.push_back(6'h13);
      expSlots.push_back(6'h14); expSlots.push_back(6'h1F);
      expSlots.push_back(6'h1B); expSlots.push_back(6'h1C);
      for (int i = 0; i < IFG + 2; i++) expSlots.push_back(6'h00);
      foreach (payload[i]) applyStimulus(payload[i], (i == 8));
      waitFrame(expSlots.size(), "fcs");
      checkFrame("fcs", findStart());
`endif

      // Reset during the fifth data nibble, then a clean frame after release.
      $display("[TB] reset mid-frame");
      slots.delete();
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h02, 1'b0);
      applyStimulus(8'h03, 1'b0);
      waitFrame(21, "rstmid");
      checkOutput("rstmid_before_en",  {31'd0, mii_tx_en}, 32'd1);
      checkOutput("rstmid_before_txd", {28'd0, mii_txd}, 32'd3);
      @(negedge clk_in);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rstmid_en",    {31'd0, mii_tx_en}, 32'd0);
      checkOutput("rstmid_txd",   {28'd0, mii_txd}, 32'd0);
      checkOutput("rstmid_busy",  {31'd0, busy}, 32'd0);
      checkOutput("rstmid_ready", {31'd0, s_ready}, 32'd1);
      repeat (3) @(posedge clk_in);
      #1;
      slots.delete();
      expSlots.delete();
      rst_n = 1'b1;
      payload = '{8'h55};
      buildExpected(IFG + 2, 1'b1);
      applyStimulus(8'h55, 1'b1);
      waitFrame(expSlots.size(), "after_rst");
      checkOutput("after_rst_start", findStart(), 32'd0);
      checkFrame("after_rst", findStart());

      checkOutput("hold_violations", holdBad, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
